// File: rtl/voice_mixer_pwm_if.sv
// Voice mixer bus: key enables and LFSR voice words in, mixed sample, PWM duty/pin and overrun out.
// Signal prefixes are from the mixer's point of view.
interface voice_mixer_pwm_if;
  logic [7:0]  i_voice_en;
  logic [7:0]  i_lfsr_1;
  logic [7:0]  i_lfsr_2;
  logic [7:0]  i_lfsr_3;
  logic [7:0]  i_lfsr_4;
  logic [7:0]  i_lfsr_5;
  logic [7:0]  i_lfsr_6;
  logic [7:0]  i_lfsr_7;
  logic [7:0]  i_lfsr_8;
  logic [10:0] o_sample;
  logic        o_sample_valid;
  logic [7:0]  o_duty;
  logic        o_pwm_out;
  logic        o_overrun;

  modport slave (
    input  i_voice_en, i_lfsr_1, i_lfsr_2, i_lfsr_3, i_lfsr_4,
           i_lfsr_5, i_lfsr_6, i_lfsr_7, i_lfsr_8,
    output o_sample, o_sample_valid, o_duty, o_pwm_out, o_overrun
  );

  modport master (
    output i_voice_en, i_lfsr_1, i_lfsr_2, i_lfsr_3, i_lfsr_4,
           i_lfsr_5, i_lfsr_6, i_lfsr_7, i_lfsr_8,
    input  o_sample, o_sample_valid, o_duty, o_pwm_out, o_overrun
  );
endinterface

// File: rtl/voice_mixer_pwm.sv
// Eight-voice mixer: one time-shared adder sums the enabled voices once per sample period,
// and the scaled sum drives an 8-bit PWM whose duty changes only at period boundaries.
module voice_mixer_pwm #(
  parameter int unsigned SAMPLE_DIV = 1024,
  parameter int unsigned MIX_SHIFT  = 3
) (
  input  logic               clk,
  input  logic               rst,
  voice_mixer_pwm_if.slave   bus
);
  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_ACCUM  = 2'd1;
  localparam logic [1:0]  S_DONE   = 2'd2;
  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

  logic [15:0] r_div_cnt;
  logic [1:0]  r_state;
  logic [2:0]  r_idx;
  logic [10:0] r_acc;
  logic [10:0] r_sample;
  logic        r_sample_valid;
  logic        r_overrun;
  logic [7:0]  r_pend;
  logic [7:0]  r_duty;
  logic [7:0]  r_pwm_cnt;
  logic        r_pwm_out;

  logic        w_tick;
  logic [7:0]  w_voice;
  logic [7:0]  w_add;
  logic [10:0] w_acc_next;
  logic [10:0] w_shifted;
  logic [7:0]  w_duty_new;
  logic        w_last_voice;

  assign w_tick       = (r_div_cnt == DIV_LAST);
  assign w_last_voice = (r_state == S_ACCUM) && (r_idx == 3'd7);

  always_comb begin
    w_voice = 8'd0;
    case (r_idx)
      3'd0:    w_voice = bus.i_lfsr_1;
      3'd1:    w_voice = bus.i_lfsr_2;
      3'd2:    w_voice = bus.i_lfsr_3;
      3'd3:    w_voice = bus.i_lfsr_4;
      3'd4:    w_voice = bus.i_lfsr_5;
      3'd5:    w_voice = bus.i_lfsr_6;
      3'd6:    w_voice = bus.i_lfsr_7;
      3'd7:    w_voice = bus.i_lfsr_8;
      default: w_voice = 8'd0;
    endcase
  end

  // The final sum is taken straight from the adder so sample and duty land together.
  always_comb begin
    w_add = 8'd0;
    if (bus.i_voice_en[r_idx]) begin
      w_add = w_voice;
    end else begin
      w_add = 8'd0;
    end
    w_acc_next = r_acc + {3'd0, w_add};
    w_shifted  = w_acc_next >> MIX_SHIFT;
    if (w_shifted > 11'd255) begin
      w_duty_new = 8'hFF;
    end else begin
      w_duty_new = w_shifted[7:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div_cnt <= 16'd0;
    end else if (w_tick) begin
      r_div_cnt <= 16'd0;
    end else begin
      r_div_cnt <= r_div_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_idx          <= 3'd0;
      r_acc          <= 11'd0;
      r_sample       <= 11'd0;
      r_sample_valid <= 1'b0;
      r_overrun      <= 1'b0;
      r_pend         <= 8'd0;
    end else begin
      r_sample_valid <= 1'b0;
      r_overrun      <= w_tick && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_tick) begin
            r_state <= S_ACCUM;
            r_acc   <= 11'd0;
            r_idx   <= 3'd0;
          end
        end
        S_ACCUM: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + 3'd1;
          if (w_last_voice) begin
            r_state        <= S_DONE;
            r_sample       <= w_acc_next;
            r_sample_valid <= 1'b1;
            r_pend         <= w_duty_new;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A duty written on the boundary cycle itself bypasses the pending register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pwm_cnt <= 8'd0;
      r_pwm_out <= 1'b0;
      r_duty    <= 8'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      r_pwm_out <= (r_pwm_cnt < r_duty);
      if (r_pwm_cnt == 8'hFF) begin
        r_duty <= w_last_voice ? w_duty_new : r_pend;
      end
    end
  end

  assign bus.o_sample       = r_sample;
  assign bus.o_sample_valid = r_sample_valid;
  assign bus.o_duty         = r_duty;
  assign bus.o_pwm_out      = r_pwm_out;
  assign bus.o_overrun      = r_overrun;
endmodule

// File: tb/tb_voice_mixer_pwm.sv
// Directed bench for voice_mixer_pwm: a SAMPLE_DIV=32 instance for mixing/PWM behaviour and
// a SAMPLE_DIV=8 instance for overrun and mid-accumulation reset.
module tb_voice_mixer_pwm;
  logic clk = 1'b0;
  logic rst;
  logic rst8;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc;
  int   e;
  int   hi;

  always #5 clk = ~clk;

  voice_mixer_pwm_if bus ();
  voice_mixer_pwm_if bus8 ();

  voice_mixer_pwm #(.SAMPLE_DIV(32), .MIX_SHIFT(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  voice_mixer_pwm #(.SAMPLE_DIV(8), .MIX_SHIFT(3)) u_dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8)
  );

  // Cycles since reset release; equals the expected PWM counter value modulo 256.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int budget, output int edges);
    edges = 0;
    while (edges < budget) begin
      @(posedge clk); #1;
      edges++;
      if (bus.o_sample_valid === 1'b1) break;
    end
  endtask

  task automatic wait_duty(input logic [7:0] want, input int budget, output int edges);
    edges = 0;
    while (edges < budget) begin
      @(posedge clk); #1;
      edges++;
      if (bus.o_duty === want) break;
    end
  endtask

  task automatic count_pwm(input int n, output int highs);
    highs = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (bus.o_pwm_out === 1'b1) highs++;
    end
  endtask

  task automatic set_lfsr_tens();
    bus.i_lfsr_1 = 8'd10; bus.i_lfsr_2 = 8'd20; bus.i_lfsr_3 = 8'd30; bus.i_lfsr_4 = 8'd40;
    bus.i_lfsr_5 = 8'd50; bus.i_lfsr_6 = 8'd60; bus.i_lfsr_7 = 8'd70; bus.i_lfsr_8 = 8'd80;
  endtask

  initial begin
    rst = 1'b1;
    rst8 = 1'b1;
    bus.i_voice_en = 8'h00;
    bus.i_lfsr_1 = 8'd0; bus.i_lfsr_2 = 8'd0; bus.i_lfsr_3 = 8'd0; bus.i_lfsr_4 = 8'd0;
    bus.i_lfsr_5 = 8'd0; bus.i_lfsr_6 = 8'd0; bus.i_lfsr_7 = 8'd0; bus.i_lfsr_8 = 8'd0;
    bus8.i_voice_en = 8'hFF;
    bus8.i_lfsr_1 = 8'd5; bus8.i_lfsr_2 = 8'd5; bus8.i_lfsr_3 = 8'd5; bus8.i_lfsr_4 = 8'd5;
    bus8.i_lfsr_5 = 8'd5; bus8.i_lfsr_6 = 8'd5; bus8.i_lfsr_7 = 8'd5; bus8.i_lfsr_8 = 8'd5;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sample", 32'(bus.o_sample), 32'd0);
    chk("rst_valid", 32'(bus.o_sample_valid), 32'd0);
    chk("rst_duty", 32'(bus.o_duty), 32'd0);
    chk("rst_pwm", 32'(bus.o_pwm_out), 32'd0);
    chk("rst_overrun", 32'(bus.o_overrun), 32'd0);

    // First sample: tick in cycle 31, voices in 32..39, valid in cycle 40
    @(negedge clk) rst = 1'b0;
    wait_valid(100, e);
    chk("first_valid_latency", 32'(e), 32'd40);
    chk("first_valid", 32'(bus.o_sample_valid), 32'd1);
    chk("first_sample", 32'(bus.o_sample), 32'd0);
    chk("idle_duty", 32'(bus.o_duty), 32'd0);
    count_pwm(64, hi);
    chk("idle_pwm_highs", 32'(hi), 32'd0);

    // Full scale: 8*255 = 2040, duty saturates at 255
    bus.i_voice_en = 8'hFF;
    bus.i_lfsr_1 = 8'hFF; bus.i_lfsr_2 = 8'hFF; bus.i_lfsr_3 = 8'hFF; bus.i_lfsr_4 = 8'hFF;
    bus.i_lfsr_5 = 8'hFF; bus.i_lfsr_6 = 8'hFF; bus.i_lfsr_7 = 8'hFF; bus.i_lfsr_8 = 8'hFF;
    wait_valid(64, e);
    chk("full_sample", 32'(bus.o_sample), 32'd2040);
    wait_duty(8'hFF, 300, e);
    chk("full_duty", 32'(bus.o_duty), 32'd255);
    repeat (3) @(posedge clk);
    count_pwm(256, hi);
    chk("full_pwm_highs", 32'(hi), 32'd255);

    // Voices 6 and 8 only: 60+80 = 140, duty 17
    wait_valid(64, e);
    set_lfsr_tens();
    bus.i_voice_en = 8'b1010_0000;
    wait_valid(64, e);
    chk("sel_sample", 32'(bus.o_sample), 32'd140);
    wait_duty(8'd17, 300, e);
    chk("sel_duty", 32'(bus.o_duty), 32'd17);

    // Key release in cycle T+4: only voices 1..3 summed (60)
    wait_valid(64, e);
    bus.i_voice_en = 8'hFF;
    repeat (27) @(posedge clk);
    #1 bus.i_voice_en = 8'h00;
    wait_valid(40, e);
    chk("release_latency", 32'(e), 32'd5);
    chk("release_sample", 32'(bus.o_sample), 32'd60);
    bus.i_voice_en = 8'b0000_0111;

    // Duty 17 -> 7 arrives mid-period; switch only at the PWM boundary
    chk("hold_duty", 32'(bus.o_duty), 32'd17);
    wait_duty(8'd7, 300, e);
    chk("new_duty", 32'(bus.o_duty), 32'd7);
    chk("duty_boundary", 32'(cyc % 256), 32'd0);
    count_pwm(256, hi);
    chk("new_pwm_highs", 32'(hi), 32'd7);

    // SAMPLE_DIV=8: tick in cycle 15 lands in ACCUM -> overrun with valid in cycle 16
    chk("r8_sample", 32'(bus8.o_sample), 32'd0);
    @(negedge clk) rst8 = 1'b0;
    e = 0;
    while (e < 40) begin
      @(posedge clk); #1;
      e++;
      if (bus8.o_overrun === 1'b1) break;
    end
    chk("ovr_latency", 32'(e), 32'd16);
    chk("ovr_valid", 32'(bus8.o_sample_valid), 32'd1);
    chk("ovr_sample", 32'(bus8.o_sample), 32'd40);
    @(posedge clk); #1;
    chk("ovr_pulse", 32'(bus8.o_overrun), 32'd0);

    // Reset in cycle 26 (ACCUM): outputs clear at once, no sample emitted while held
    repeat (9) @(posedge clk);
    #1 rst8 = 1'b1;
    #1;
    chk("mid_rst_sample", 32'(bus8.o_sample), 32'd0);
    chk("mid_rst_valid", 32'(bus8.o_sample_valid), 32'd0);
    chk("mid_rst_duty", 32'(bus8.o_duty), 32'd0);
    chk("mid_rst_pwm", 32'(bus8.o_pwm_out), 32'd0);
    hi = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus8.o_sample_valid !== 1'b0) hi++;
    end
    chk("mid_rst_no_valid", 32'(hi), 32'd0);
    @(negedge clk) rst8 = 1'b0;
    e = 0;
    while (e < 40) begin
      @(posedge clk); #1;
      e++;
      if (bus8.o_sample_valid === 1'b1) break;
    end
    chk("rerun_latency", 32'(e), 32'd16);
    chk("rerun_sample", 32'(bus8.o_sample), 32'd40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
